// File: rtl/ftdi_reg_bridge.sv
// Register-access command bridge between the FTDI byte controller and an
// internal register bus; read replies go back out over the TX handshake.
module ftdi_reg_bridge #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TX_HOLD_CYCLES = 12
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic       in_rx_me_rdy,
  input  logic [7:0] in_rx_data,
  output logic       out_rx_cons_rdy,
  output logic       out_rx_ena,
  output logic       out_tx_data_rdy,
  input  logic       in_tx_me_rdy,
  output logic [7:0] out_tx_data,
  output logic [6:0] out_reg_addr,
  output logic [7:0] out_reg_wdata,
  output logic       out_reg_we,
  output logic       out_reg_re,
  input  logic [7:0] in_reg_rdata,
  output logic [7:0] out_err_cnt,
  output logic       out_busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(TX_HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_ACK,
    S_WAIT_DATA,
    S_REG_WR,
    S_REG_RD,
    S_RD_CAP,
    S_TX_REQ,
    S_TX_HOLD
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_cmd;
  logic [7:0]      r_wdata;
  logic [7:0]      r_tx_data;
  logic [7:0]      r_err_cnt;
  logic            r_second;
  logic [TW-1:0]   r_to_cnt;
  logic [HW-1:0]   r_hold_cnt;
  logic            w_to_hit;
  logic            w_hold_done;

  assign w_to_hit    = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_hold_done = (r_hold_cnt == HW'(TX_HOLD_CYCLES - 1));

  always_comb begin
    w_next          = r_state;
    out_rx_cons_rdy = 1'b0;
    out_rx_ena      = 1'b1;
    out_tx_data_rdy = 1'b0;
    out_reg_we      = 1'b0;
    out_reg_re      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (in_rx_me_rdy) w_next = S_RX_ACK;
      end
      S_RX_ACK: begin
        out_rx_cons_rdy = 1'b1;
        // a latched read command must block the next RX until the reply
        out_rx_ena      = r_cmd[7];
        if (!in_rx_me_rdy) begin
          if (r_second)      w_next = S_REG_WR;
          else if (r_cmd[7]) w_next = S_WAIT_DATA;
          else               w_next = S_REG_RD;
        end
      end
      S_WAIT_DATA: begin
        if (in_rx_me_rdy)  w_next = S_RX_ACK;
        else if (w_to_hit) w_next = S_IDLE;
      end
      S_REG_WR: begin
        out_reg_we = 1'b1;
        w_next     = S_IDLE;
      end
      S_REG_RD: begin
        out_reg_re = 1'b1;
        out_rx_ena = 1'b0;
        w_next     = S_RD_CAP;
      end
      S_RD_CAP: begin
        out_rx_ena = 1'b0;
        w_next     = S_TX_REQ;
      end
      S_TX_REQ: begin
        out_rx_ena      = 1'b0;
        out_tx_data_rdy = 1'b1;
        if (in_tx_me_rdy) w_next = S_TX_HOLD;
      end
      S_TX_HOLD: begin
        out_rx_ena = 1'b0;
        if (w_hold_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state    <= S_IDLE;
      r_cmd      <= '0;
      r_wdata    <= '0;
      r_tx_data  <= '0;
      r_err_cnt  <= '0;
      r_second   <= 1'b0;
      r_to_cnt   <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (in_rx_me_rdy) begin
            r_cmd    <= in_rx_data;
            r_second <= 1'b0;
          end
        end
        S_RX_ACK: r_to_cnt <= '0;
        S_WAIT_DATA: begin
          if (in_rx_me_rdy) begin
            r_wdata  <= in_rx_data;
            r_second <= 1'b1;
          end else if (w_to_hit) begin
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        S_REG_WR:  r_second   <= 1'b0;
        S_RD_CAP:  r_tx_data  <= in_reg_rdata;
        S_TX_REQ:  r_hold_cnt <= '0;
        S_TX_HOLD: r_hold_cnt <= r_hold_cnt + HW'(1);
        default: ;
      endcase
    end
  end

  assign out_tx_data   = r_tx_data;
  assign out_reg_addr  = r_cmd[6:0];
  assign out_reg_wdata = r_wdata;
  assign out_err_cnt   = r_err_cnt;
  assign out_busy      = (r_state != S_IDLE);

endmodule
